booth_mult_param: RTL

BOOTH_MULT_PARAM -- requirements
Module: booth_mult_param

---
 rtl/booth_mult_param.sv | 116 +++++++++++
 1 files changed

// File: rtl/booth_mult_param.sv
// Sequential Booth multiplier (radix-2 by default) that handles signed and unsigned operands.
// Defining BOOTH_RADIX4_EN selects radix-4 modified Booth recoding, which shortens each operation.
module booth_mult_param #(
  parameter int unsigned WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               signed_mode,
  input  logic               cancel,
  input  logic [WIDTH-1:0]   mult_op1,
  input  logic [WIDTH-1:0]   mult_op2,
  output logic               busy,
  output logic               is_done,
  output logic [2*WIDTH-1:0] result
);

  localparam int unsigned XW = WIDTH + 2;  // extended operand width
  localparam int unsigned AW = WIDTH + 4;  // accumulator width, leaves headroom for +/-2X
`ifdef BOOTH_RADIX4_EN
  localparam int unsigned STEPS = WIDTH / 2 + 1;
  localparam int unsigned SHIFT = 2;
`else
  localparam int unsigned STEPS = WIDTH + 1;
  localparam int unsigned SHIFT = 1;
`endif
  // The multiplier bits that have not yet been consumed stay below the product.
  localparam int unsigned RES_LSB = XW - STEPS * SHIFT;
  localparam int unsigned CW      = $clog2(STEPS + 1);

  typedef enum logic [1:0] {IDLE, ACC, DONE} state_t;

  state_t            state, state_next;
  logic [XW-1:0]     mcand;
  logic [AW+XW-1:0]  prod, prod_step;
  logic              guard, guard_step;
  logic [CW-1:0]     count;
  logic              last_step;
  logic [AW-1:0]     x_ext, pp, sum;

  assign last_step = (count == CW'(STEPS - 1));
  assign x_ext     = {{(AW-XW){mcand[XW-1]}}, mcand};
  assign busy      = (state == ACC) || (state == DONE);

  always_comb begin
    pp = '0;
`ifdef BOOTH_RADIX4_EN
    case ({prod[1:0], guard})
      3'b001, 3'b010: pp = x_ext;
      3'b011:         pp = x_ext << 1;
      3'b100:         pp = -(x_ext << 1);
      3'b101, 3'b110: pp = -x_ext;
      default:        pp = '0;
    endcase
`else
    case ({prod[0], guard})
      2'b01:   pp = x_ext;
      2'b10:   pp = -x_ext;
      default: pp = '0;
    endcase
`endif
    sum        = prod[AW+XW-1:XW] + pp;
    // Arithmetic right shift of {acc, multiplier}; the bits shifted out feed the next guard.
    prod_step  = {{SHIFT{sum[AW-1]}}, sum, prod[XW-1:SHIFT]};
    guard_step = prod[SHIFT-1];
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = ACC;
      ACC:     if (cancel) state_next = IDLE;
               else if (last_step) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mcand   <= '0;
      prod    <= '0;
      guard   <= 1'b0;
      count   <= '0;
      is_done <= 1'b0;
      result  <= '0;
    end else begin
      is_done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          mcand <= signed_mode ? {{2{mult_op1[WIDTH-1]}}, mult_op1} : {2'b00, mult_op1};
          prod  <= {{AW{1'b0}},
                    (signed_mode ? {{2{mult_op2[WIDTH-1]}}, mult_op2} : {2'b00, mult_op2})};
          guard <= 1'b0;
          count <= '0;
        end
        ACC: if (!cancel) begin
          prod  <= prod_step;
          guard <= guard_step;
          count <= count + CW'(1);
          if (last_step) begin
            result  <= prod_step[RES_LSB +: 2*WIDTH];
            is_done <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
